// File: rtl/execute_unit.sv
// execute_unit: multicycle execute stage of the LEGv8 core.
// Computes ALU result and NZCV flags from the latched operands. MUL runs as a
// 32-step shift-add. Branch target and taken decision are resolved alongside.
// Ports:
//   clock, reset         rising-edge clock, synchronous active-high reset
//   start                operands valid, sampled only when idle
//   aluOp, branchKind    operation select, branch kind (00 none/01 B/10 CBZ/11 CBNZ)
//   operandA, operandB   prepared operands
//   pcOffset, pcCurrent  sign-extended word offset, address of the instruction
//   busy, done           operation in flight, one-cycle completion pulse
//   result, flagN/Z/C/V  ALU/MUL result and condition flags
//   branchTaken, branchTarget  branch decision and target address
module execute_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       aluOp,
   input  logic [1:0]       branchKind,
   input  logic [WIDTH-1:0] operandA,
   input  logic [WIDTH-1:0] operandB,
   input  logic [WIDTH-1:0] pcOffset,
   input  logic [WIDTH-1:0] pcCurrent,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             flagN,
   output logic             flagZ,
   output logic             flagC,
   output logic             flagV,
   output logic             branchTaken,
   output logic [WIDTH-1:0] branchTarget
);

   localparam int unsigned STEP_W    = 6;
   localparam int unsigned SUM_W     = WIDTH + 1;
   localparam int unsigned LAST_STEP = WIDTH - 1;

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] EXEC   = 2'd1;
   localparam logic [1:0] MULT   = 2'd2;
   localparam logic [1:0] FINISH = 2'd3;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_ORR = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_EOR = 4'b0011;
   localparam logic [3:0] OP_LSL = 4'b0100;
   localparam logic [3:0] OP_LSR = 4'b0101;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_PSB = 4'b0111;
   localparam logic [3:0] OP_MUL = 4'b1000;
   localparam logic [3:0] OP_NOR = 4'b1100;

   logic [1:0]        state, stateNext;
   logic [3:0]        opReg, opNext;
   logic [1:0]        kindReg, kindNext;
   logic [WIDTH-1:0]  aReg, aNext;
   logic [WIDTH-1:0]  bReg, bNext;
   logic [WIDTH-1:0]  offReg, offNext;
   logic [WIDTH-1:0]  pcReg, pcNext;
   logic [WIDTH-1:0]  acc, accNext;
   logic [WIDTH-1:0]  mcand, mcandNext;
   logic [WIDTH-1:0]  mplier, mplierNext;
   logic [STEP_W-1:0] stepCount, stepNext;

   logic              busyNext, doneNext;
   logic [WIDTH-1:0]  resultNext, targetNext;
   logic              nNext, zNext, cNext, vNext, takenNext;

   logic [SUM_W-1:0]  addSum, subSum;
   logic [WIDTH-1:0]  aluRes;
   logic              aluC, aluV;
   logic [WIDTH-1:0]  targetCalc;

   // Branch decision from the zero flag of the finished operation.
   function automatic logic resolveTaken(input logic [1:0] kind, input logic zero);
      logic taken;
      case (kind)
         2'b01:   taken = 1'b1;
         2'b10:   taken = zero;
         2'b11:   taken = ~zero;
         default: taken = 1'b0;
      endcase
      return taken;
   endfunction

   // Single-cycle ALU on the latched operands; SUB is A + ~B + 1 so C=1 means no borrow.
   always_comb begin
      addSum     = {1'b0, aReg} + {1'b0, bReg};
      subSum     = {1'b0, aReg} + {1'b0, ~bReg} + SUM_W'(1);
      aluRes     = '0;
      aluC       = 1'b0;
      aluV       = 1'b0;
      targetCalc = pcReg + (offReg << 2);
      case (opReg)
         OP_AND: aluRes = aReg & bReg;
         OP_ORR: aluRes = aReg | bReg;
         OP_ADD: begin
            aluRes = addSum[WIDTH-1:0];
            aluC   = addSum[WIDTH];
            aluV   = (aReg[WIDTH-1] == bReg[WIDTH-1]) && (aluRes[WIDTH-1] != aReg[WIDTH-1]);
         end
         OP_EOR: aluRes = aReg ^ bReg;
         OP_LSL: aluRes = aReg << bReg[4:0];
         OP_LSR: aluRes = aReg >> bReg[4:0];
         OP_SUB: begin
            aluRes = subSum[WIDTH-1:0];
            aluC   = subSum[WIDTH];
            aluV   = (aReg[WIDTH-1] != bReg[WIDTH-1]) && (aluRes[WIDTH-1] != aReg[WIDTH-1]);
         end
         OP_PSB: aluRes = bReg;
         OP_NOR: aluRes = ~(aReg | bReg);
         default: aluRes = '0;
      endcase
   end

   // Next-state and next-output logic.
   always_comb begin
      stateNext  = state;
      opNext     = opReg;
      kindNext   = kindReg;
      aNext      = aReg;
      bNext      = bReg;
      offNext    = offReg;
      pcNext     = pcReg;
      accNext    = acc;
      mcandNext  = mcand;
      mplierNext = mplier;
      stepNext   = stepCount;
      doneNext   = 1'b0;
      resultNext = result;
      nNext      = flagN;
      zNext      = flagZ;
      cNext      = flagC;
      vNext      = flagV;
      takenNext  = branchTaken;
      targetNext = branchTarget;

      case (state)
         IDLE: begin
            if (start) begin
               opNext     = aluOp;
               kindNext   = branchKind;
               aNext      = operandA;
               bNext      = operandB;
               offNext    = pcOffset;
               pcNext     = pcCurrent;
               accNext    = '0;
               mcandNext  = operandA;
               mplierNext = operandB;
               stepNext   = '0;
               stateNext  = (aluOp == OP_MUL) ? MULT : EXEC;
            end
         end
         EXEC: begin
            resultNext = aluRes;
            nNext      = aluRes[WIDTH-1];
            zNext      = (aluRes == '0);
            cNext      = aluC;
            vNext      = aluV;
            takenNext  = resolveTaken(kindReg, aluRes == '0);
            targetNext = targetCalc;
            doneNext   = 1'b1;
            stateNext  = IDLE;
         end
         MULT: begin
            // Only the low word of the product is kept, so the shifted
            // multiplicand may drop its upper bits.
            if (mplier[0]) accNext = acc + mcand;
            mcandNext  = mcand << 1;
            mplierNext = mplier >> 1;
            stepNext   = stepCount + STEP_W'(1);
            if (stepCount == STEP_W'(LAST_STEP)) stateNext = FINISH;
         end
         FINISH: begin
            resultNext = acc;
            nNext      = acc[WIDTH-1];
            zNext      = (acc == '0);
            cNext      = 1'b0;
            vNext      = 1'b0;
            takenNext  = resolveTaken(kindReg, acc == '0);
            targetNext = targetCalc;
            doneNext   = 1'b1;
            stateNext  = IDLE;
         end
         default: stateNext = IDLE;
      endcase

      // busy drops in the done cycle so a new start is accepted back-to-back.
      busyNext = (stateNext != IDLE);
   end

   // State and output registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= IDLE;
         opReg        <= '0;
         kindReg      <= '0;
         aReg         <= '0;
         bReg         <= '0;
         offReg       <= '0;
         pcReg        <= '0;
         acc          <= '0;
         mcand        <= '0;
         mplier       <= '0;
         stepCount    <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result       <= '0;
         flagN        <= 1'b0;
         flagZ        <= 1'b0;
         flagC        <= 1'b0;
         flagV        <= 1'b0;
         branchTaken  <= 1'b0;
         branchTarget <= '0;
      end else begin
         state        <= stateNext;
         opReg        <= opNext;
         kindReg      <= kindNext;
         aReg         <= aNext;
         bReg         <= bNext;
         offReg       <= offNext;
         pcReg        <= pcNext;
         acc          <= accNext;
         mcand        <= mcandNext;
         mplier       <= mplierNext;
         stepCount    <= stepNext;
         busy         <= busyNext;
         done         <= doneNext;
         result       <= resultNext;
         flagN        <= nNext;
         flagZ        <= zNext;
         flagC        <= cNext;
         flagV        <= vNext;
         branchTaken  <= takenNext;
         branchTarget <= targetNext;
      end
   end

endmodule

// File: tb/tb_execute_unit.sv
// tb_execute_unit: scoreboard bench for execute_unit. Stimulus pushes the
// hand-computed response; a monitor pops and compares on every done pulse.
module tb_execute_unit;

   typedef struct packed {
      logic [31:0] res;
      logic        n, z, c, v, taken;
      logic [31:0] target;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset, start;
   logic [3:0]  aluOp;
   logic [1:0]  branchKind;
   logic [31:0] operandA, operandB, pcOffset, pcCurrent;
   logic        busy, done, flagN, flagZ, flagC, flagV, branchTaken;
   logic [31:0] result, branchTarget;

   int    assertions = 0;
   int    failures   = 0;
   exp_t  expQ[$];
   string nameQ[$];

   execute_unit #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset), .start(start), .aluOp(aluOp),
      .branchKind(branchKind), .operandA(operandA), .operandB(operandB),
      .pcOffset(pcOffset), .pcCurrent(pcCurrent), .busy(busy), .done(done),
      .result(result), .flagN(flagN), .flagZ(flagZ), .flagC(flagC),
      .flagV(flagV), .branchTaken(branchTaken), .branchTarget(branchTarget)
   );

   always #5 clock = ~clock;

   function automatic exp_t mk(input logic [31:0] r, input logic n, z, c, v, t,
                               input logic [31:0] tgt);
      exp_t e;
      e.res = r; e.n = n; e.z = z; e.c = c; e.v = v; e.taken = t; e.target = tgt;
      return e;
   endfunction

   task automatic checkVal(input string name, input logic [127:0] act, input logic [127:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest pending expectation.
   always @(posedge clock) begin
      exp_t  e;
      exp_t  a;
      string nm;
      #1;
      if (done) begin
         assertions++;
         if (expQ.size() == 0) begin
            failures++;
            $display("FAIL unexpectedDone: done with nothing pending, result=%h", result);
         end else begin
            e  = expQ.pop_front();
            nm = nameQ.pop_front();
            a  = mk(result, flagN, flagZ, flagC, flagV, branchTaken, branchTarget);
            if (a !== e) begin
               failures++;
               $display("FAIL %s: got result=%h NZCV=%b%b%b%b taken=%b target=%h, expected result=%h NZCV=%b%b%b%b taken=%b target=%h",
                        nm, a.res, a.n, a.z, a.c, a.v, a.taken, a.target,
                        e.res, e.n, e.z, e.c, e.v, e.taken, e.target);
            end
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [1:0] kind,
                        input logic [31:0] a, b, off, pc);
      aluOp = op; branchKind = kind; operandA = a; operandB = b;
      pcOffset = off; pcCurrent = pc; start = 1'b1;
   endtask

   // Takes the accepting edge, then scrambles inputs that must no longer matter.
   task automatic acceptEdge();
      @(posedge clock); #1;
      start = 1'b0;
      aluOp = 4'b0010; branchKind = 2'b01;
      operandA = 32'hDEADBEEF; operandB = 32'h12345678;
      pcOffset = 32'h00000777; pcCurrent = 32'hABCD0000;
   endtask

   task automatic waitDone(input int lat, input string name);
      int cycles = 0;
      bit got    = 1'b0;
      bit busyOk = 1'b1;
      while (!got && cycles < 100) begin
         @(posedge clock); #1;
         cycles++;
         if (done) got = 1'b1;
         else if (busy !== 1'b1) busyOk = 1'b0;
      end
      checkVal({name, "_latency"}, 128'(cycles), 128'(lat));
      checkVal({name, "_busyHeld"}, 128'(busyOk), 128'd1);
      checkVal({name, "_busyLowAtDone"}, 128'(busy), 128'd0);
   endtask

   task automatic runOp(input logic [3:0] op, input logic [1:0] kind,
                        input logic [31:0] a, b, off, pc,
                        input exp_t e, input int lat, input string name);
      issue(op, kind, a, b, off, pc);
      expQ.push_back(e);
      nameQ.push_back(name);
      acceptEdge();
      checkVal({name, "_busyAfterStart"}, 128'(busy), 128'd1);
      waitDone(lat, name);
   endtask

   function automatic logic [127:0] allOuts();
      return 128'({busy, done, result, flagN, flagZ, flagC, flagV, branchTaken, branchTarget});
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int dones;
      reset = 1'b1; start = 1'b0; aluOp = '0; branchKind = '0;
      operandA = '0; operandB = '0; pcOffset = '0; pcCurrent = '0;
      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      checkVal("resetState", allOuts(), 128'd0);

      // Arithmetic and flags
      runOp(4'b0010, 2'b00, 32'h7FFFFFFF, 32'h1, 32'h1, 32'h1000,
            mk(32'h80000000, 1, 0, 0, 1, 0, 32'h1004), 1, "add_ovf");
      runOp(4'b0110, 2'b00, 32'd5, 32'd5, 32'h0, 32'h0,
            mk(32'h0, 0, 1, 1, 0, 0, 32'h0), 1, "sub_equal");
      runOp(4'b0110, 2'b00, 32'd3, 32'd5, 32'h0, 32'h0,
            mk(32'hFFFFFFFE, 1, 0, 0, 0, 0, 32'h0), 1, "sub_borrow");
      runOp(4'b0010, 2'b00, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0,
            mk(32'h0, 0, 1, 1, 0, 0, 32'h0), 1, "add_carry");

      // MUL
      runOp(4'b1000, 2'b10, 32'h00010003, 32'h7, 32'h0, 32'h0,
            mk(32'h00070015, 0, 0, 0, 0, 0, 32'h0), 33, "mul_small");
      runOp(4'b1000, 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0,
            mk(32'h1, 0, 0, 0, 0, 1, 32'h0), 33, "mul_max");

      // CBZ
      runOp(4'b0111, 2'b10, 32'h55, 32'h0, 32'hFFFFFFFE, 32'h100,
            mk(32'h0, 0, 1, 0, 0, 1, 32'hF8), 1, "cbz_taken");
      runOp(4'b0111, 2'b10, 32'h55, 32'h3, 32'hFFFFFFFE, 32'h100,
            mk(32'h3, 0, 0, 0, 0, 0, 32'hF8), 1, "cbz_not_taken");

      // MUL with an ignored start mid-flight, then a back-to-back AND
      issue(4'b1000, 2'b00, 32'd3, 32'd5, 32'h0, 32'h0);
      expQ.push_back(mk(32'hF, 0, 0, 0, 0, 0, 32'h0));
      nameQ.push_back("mul_busy_reject");
      acceptEdge();
      repeat (4) @(posedge clock);
      #1 issue(4'b0010, 2'b01, 32'd100, 32'd200, 32'h10, 32'h10);
      acceptEdge();
      waitDone(28, "mul_busy_reject");
      runOp(4'b0000, 2'b00, 32'hF0F0, 32'hFF00, 32'h0, 32'h0,
            mk(32'hF000, 0, 0, 0, 0, 0, 32'h0), 1, "and_back_to_back");

      // Reset mid-MUL: outputs cleared, no done for the aborted operation
      issue(4'b1000, 2'b00, 32'h00010003, 32'h7, 32'h4, 32'h40);
      acceptEdge();
      repeat (9) @(posedge clock);
      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      checkVal("resetMidMul_outputs", allOuts(), 128'd0);
      dones = 0;
      repeat (40) begin
         @(posedge clock); #1;
         if (done) dones++;
      end
      checkVal("resetMidMul_noDone", 128'(dones), 128'd0);
      runOp(4'b0010, 2'b00, 32'd2, 32'd3, 32'h0, 32'h0,
            mk(32'h5, 0, 0, 0, 0, 0, 32'h0), 1, "add_after_reset");

      // Reset and start on the same edge: start dropped
      issue(4'b0010, 2'b00, 32'd7, 32'd8, 32'h0, 32'h0);
      reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0; start = 1'b0;
      checkVal("resetWithStart_busy", 128'(busy), 128'd0);
      @(posedge clock);
      #1 checkVal("resetWithStart_noDone", 128'(done), 128'd0);

      // Logic, shifts, NOR, undefined opcode
      runOp(4'b0001, 2'b00, 32'hF0, 32'h0F, 32'h0, 32'h0,
            mk(32'hFF, 0, 0, 0, 0, 0, 32'h0), 1, "orr");
      runOp(4'b0011, 2'b00, 32'hFF, 32'h0F, 32'h0, 32'h0,
            mk(32'hF0, 0, 0, 0, 0, 0, 32'h0), 1, "eor");
      runOp(4'b0100, 2'b00, 32'h1, 32'd31, 32'h0, 32'h0,
            mk(32'h80000000, 1, 0, 0, 0, 0, 32'h0), 1, "lsl31");
      runOp(4'b0100, 2'b00, 32'h1234, 32'h20, 32'h0, 32'h0,
            mk(32'h1234, 0, 0, 0, 0, 0, 32'h0), 1, "lsl_by_zero");
      runOp(4'b0101, 2'b11, 32'h80000000, 32'd31, 32'h3, 32'h200,
            mk(32'h1, 0, 0, 0, 0, 1, 32'h20C), 1, "lsr31_cbnz");
      runOp(4'b1100, 2'b01, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h40,
            mk(32'hFFFFFFFF, 1, 0, 0, 0, 1, 32'h3C), 1, "nor_b");
      runOp(4'b1111, 2'b00, 32'h1234, 32'h5678, 32'h0, 32'h0,
            mk(32'h0, 0, 1, 0, 0, 0, 32'h0), 1, "undefined_op");

      repeat (3) @(posedge clock);
      #1 checkVal("scoreboardDrained", 128'(expQ.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/execute_unit.md
# execute_unit

Multicycle execute stage of the LEGv8 core, directly downstream of operand preparation. It consumes the two prepared operands and the sign-extended PC offset and computes the ALU result and NZCV flags. Single-cycle ALU operations finish quickly; MUL runs as an iterative 32-step shift-add. Branch target and taken decision are resolved in the same stage and presented to the PC/writeback logic with a one-cycle `done` pulse.

## Interface
- `WIDTH`, 32, datapath width; only 32 is supported.
- `clock`  in  1  main clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  operands valid; sampled only in IDLE.
- `aluOp`  in  4  operation select (see Operation).
- `branchKind`  in  2  00 none, 01 B (unconditional), 10 CBZ, 11 CBNZ.
- `operandA`  in  32  first operand (register data 1).
- `operandB`  in  32  second operand (register data 2 or immediate).
- `pcOffset`  in  32  sign-extended word offset.
- `pcCurrent`  in  32  address of the executing instruction.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse: outputs updated.
- `result`  out  32  ALU/MUL result.
- `flagN`, `flagZ`, `flagC`, `flagV`  out  1 each  condition flags.
- `branchTaken`  out  1  branch decision.
- `branchTarget`  out  32  `pcCurrent + (pcOffset << 2)`, modulo 2^32.

## Operation
- States: IDLE, EXEC, MULT, FINISH.
- IDLE: `busy`=0. When `start`=1 at an edge, latch all inputs. Go to MULT if `aluOp`=1000; otherwise go to EXEC. `busy`=1 from the next cycle.
- EXEC: compute from the latched values, register all outputs, pulse `done`, return to IDLE.
- Operation codes:
  - 0000: AND.
  - 0001: ORR.
  - 0010: ADD.
  - 0011: EOR.
  - 0100: LSL by `operandB[4:0]`.
  - 0101: LSR (logical) by `operandB[4:0]`.
  - 0110: SUB (A−B).
  - 0111: pass B.
  - 1000: MUL.
  - 1100: NOR.
  - Any other code: result 0.
- Flags:
  - N = `result[31]`; Z = (`result`==0).
  - ADD: C = carry-out of bit 31; V = signed overflow.
  - SUB: computed as A + ~B + 1. C = carry-out, so C=1 means no borrow. V = signed overflow.
  - All other operations: C=0, V=0.
- MUL:
  - Unsigned shift-add. Keep a 6-bit step counter, an accumulator, the multiplicand shifted left, and the multiplier shifted right.
  - Each MULT cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator; then advance.
  - After 32 steps, go to FINISH.
  - The low 32 bits of the product go to `result`. The upper bits are discarded.
- FINISH: register the MUL outputs, pulse `done`, return to IDLE.
- Branch resolution, registered together with `done`:
  - `branchTarget` is always computed.
  - `branchTaken`: kind 01 gives 1; kind 10 gives Z of the result; kind 11 gives !Z; kind 00 gives 0.
- `start` while `busy`=1 is ignored: no queueing, no effect on the in-flight operation.
- Outputs hold their last values between `done` pulses.

## Timing
- Reset values: every output is 0 (`busy`, `done`, `result`, all four flags, `branchTaken`, `branchTarget`); state IDLE; step counter 0.
- Latency:
  - Non-MUL operation with `start` at edge k: `done`=1 and outputs valid after edge k+1; `busy`=1 only during that cycle.
  - MUL with `start` at edge k: MULT occupies edges k+1..k+32, FINISH is at edge k+33, and `done`=1 after edge k+33. `busy`=1 after edges k..k+32.
- `done` is high for exactly one cycle. In that same cycle `busy`=0, so `start` may be asserted in the `done` cycle and is accepted back-to-back.
- Inputs only need to be valid at the edge where `start` is accepted; later changes have no effect.
- Reset mid-operation, including mid-MUL: at that edge go to IDLE and clear all outputs. No `done` is issued for the aborted operation.
- `reset` and `start` at the same edge: reset wins and `start` is dropped.
- Wrap-around: ADD/SUB/MUL/`branchTarget` are all modulo 2^32. Shift amount 0 passes A unchanged.

## Test plan
- ADD: A=0x7FFFFFFF, B=1, start once → `done` after 2 edges; result 0x80000000, N=1, Z=0, C=0, V=1. Then SUB with A=5, B=5 → result 0, Z=1, C=1, V=0.
- MUL: A=0x00010003, B=0x00000007 → `busy` for 33 cycles, `done` after edge k+33, result 0x00070015, flags C=V=0. Also A=B=0xFFFFFFFF → result 0x00000001.
- CBZ: kind 10, aluOp 0111, B=0, pcCurrent=0x100, pcOffset=0xFFFFFFFE → branchTaken=1, branchTarget=0x000000F8. Repeat with B=3 → branchTaken=0, target unchanged.
- Busy rejection and back-to-back:
  - Start MUL, then pulse `start` with aluOp=ADD at cycle 5 → ignored; only the MUL result appears.
  - Then assert `start` (AND, A=0xF0F0, B=0xFF00) in the `done` cycle → result 0xF000 exactly one edge later.
- Reset mid-MUL: assert reset at step 10 → the next cycle shows all outputs 0 and `busy`=0, and no `done` pulse follows. A fresh ADD 2+3 afterwards gives 5.
- Shifts/NOR: LSL A=1, B=31 → 0x80000000, N=1. LSR A=0x80000000, B=31 → 1. NOR A=0, B=0 → 0xFFFFFFFF. Undefined aluOp 1111 → result 0, Z=1.
